scale_mux_arb: RTL and testbench
================================

Name: scale_mux_arb

Overview:
- Upstream feeder for the 8-bit 2:1 scale mux.
- Accepts two independent valid/ready byte streams (A, B) into one-entry holding registers.
- Arbitrates between them with burst-limited round-robin, then drives the mux data inputs and select.
- Presents a single valid/ready handshake toward the consumer of the mux output.

Parameters:
- WIDTH, 8, data width of each channel and of the mux inputs; must be 8 to match the mux.
- BURST, 1, max consecutive grants to one channel while the other is waiting; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a_data  input  WIDTH  channel A data
- a_valid  input  1  channel A valid
- a_ready  output  1  channel A ready
- b_data  input  WIDTH  channel B data
- b_valid  input  1  channel B valid
- b_ready  output  1  channel B ready
- mux_in_a  output  WIDTH  to mux in_a (channel A holding register)
- mux_in_b  output  WIDTH  to mux in_b (channel B holding register)
- mux_sel_a  output  1  to mux sel_a (1 = A granted)
- out_valid  output  1  mux output carries a valid byte
- out_ready  input  1  consumer accepts the mux output this cycle

Behaviour:
- Reset (rst_n low at a clk edge):
  - full_a = full_b = 0; hold_a = hold_b = 0.
  - pref = A, run_cnt = 0, state = IDLE, last_sel = 1.
  - Resulting outputs: mux_in_a = mux_in_b = 0, mux_sel_a = 1, out_valid = 0.
  - a_ready and b_ready are forced 0 while rst_n is low.
  - Reset mid-transfer discards held data with no output fire.
- Capture:
  - a_fire = a_valid & a_ready loads hold_a and sets full_a; B is symmetric.
  - mux_in_a = hold_a and mux_in_b = hold_b, driven directly from the registers.
- Output handshake:
  - out_valid = full_a | full_b.
  - fire = out_valid & out_ready clears the full flag of the granted channel.
- Ready:
  - a_ready = ~full_a | (fire & grant==A); B is symmetric.
  - This allows a same-cycle refill, giving 1 transfer/cycle sustained throughput.
  - Ready depends combinationally on out_ready.
- Latency: data accepted in cycle N appears with out_valid in cycle N+1.
- Grant selection in IDLE (combinational):
  - only A full → A; only B full → B.
  - both full → pref if run_cnt < BURST, else ~pref.
  - neither full → last_sel (mux_sel_a holds its previous value).
- FSM, states IDLE and OFFER:
  - IDLE, out_valid & ~out_ready → OFFER; grant_q latches the IDLE choice.
  - OFFER: mux_sel_a = grant_q. The grant must not change while stalled, even if the other channel fills.
  - OFFER, out_ready → fire on grant_q, then IDLE.
  - IDLE, fire → stay IDLE.
- Round-robin update on every fire of channel X:
  - X != pref → pref = X, run_cnt = 1.
  - X == pref → run_cnt = min(run_cnt+1, BURST).
  - last_sel = X.
- run_cnt width is $clog2(BURST+1) and saturates; no wrap.
- Simultaneous events: capture into a channel and fire of the same channel in one cycle leaves full = 1 with the new data.

Optional Feature:
- Macro SCALE_MUX_ARB_STATS_EN.
- When defined, adds two outputs:
  - grant_cnt_a [15:0]: count of fires granted to A.
  - grant_cnt_b [15:0]: count of fires granted to B.
  - Both are 0 on reset and saturate at 16'hFFFF.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with a_valid=b_valid=1 → a_ready=b_ready=0, out_valid=0, mux_sel_a=1, mux_in_a=mux_in_b=8'h00.
- Single channel: send A byte 8'h5A with out_ready=1 → cycle+1: out_valid=1, mux_sel_a=1, mux_in_a=8'h5A; cycle+2: out_valid=0.
- Round-robin, BURST=1: both channels stream (A 8'h10..8'h13, B 8'h20..8'h23) with out_ready=1 → grant order A,B,A,B,...; out sequence 10,20,11,21,12,22,13,23.
- Burst limit, BURST=3: both streams continuous → grant pattern AAABBBAAA; run_cnt never exceeds 3.
- Stall lock: B full, out_ready=0 for 4 cycles, A arrives in stall cycle 2 → mux_sel_a stays 0 and mux_in_b is unchanged until out_ready=1; B fires first, then A.
- Stats (macro defined): 5 A fires and 3 B fires → grant_cnt_a=5, grant_cnt_b=3. Synchronous reset mid-stream → both counters 0 and out_valid=0 on the next cycle.

Source files
------------

// File: rtl/scale_mux_arb.sv
// Feeder for the 8-bit 2:1 scale mux: two one-entry byte holding registers,
// burst-limited round-robin arbitration, single valid/ready toward the consumer.
// Optional per-channel grant counters are enabled with SCALE_MUX_ARB_STATS_EN.
module scale_mux_arb #(
  parameter int WIDTH = 8,
  parameter int BURST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] mux_in_a,
  output logic [WIDTH-1:0] mux_in_b,
  output logic             mux_sel_a,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SCALE_MUX_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt_a,
  output logic [15:0]      grant_cnt_b
`endif
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state_r;
  logic             full_a_r;
  logic             full_b_r;
  logic [WIDTH-1:0] hold_a_r;
  logic [WIDTH-1:0] hold_b_r;
  logic             grant_q_r;
  logic             pref_r;
  logic [CW-1:0]    run_cnt_r;
  logic             last_sel_r;

  logic             grant_a_s;
  logic             fire_s;
  logic             a_fire_s;
  logic             b_fire_s;

  // Grant choice: frozen while stalled in OFFER, otherwise arbitrated from the full flags.
  always_comb begin
    grant_a_s = last_sel_r;
    if (state_r == OFFER) begin
      grant_a_s = grant_q_r;
    end else begin
      case ({full_a_r, full_b_r})
        2'b10:   grant_a_s = 1'b1;
        2'b01:   grant_a_s = 1'b0;
        2'b11:   grant_a_s = (run_cnt_r < BURST_C) ? pref_r : ~pref_r;
        default: grant_a_s = last_sel_r;
      endcase
    end
  end

  assign out_valid = full_a_r | full_b_r;
  assign fire_s    = out_valid & out_ready;
  // A granted channel that fires can be refilled in the same cycle.
  assign a_ready   = rst_n & (~full_a_r | (fire_s & grant_a_s));
  assign b_ready   = rst_n & (~full_b_r | (fire_s & ~grant_a_s));
  assign a_fire_s  = a_valid & a_ready;
  assign b_fire_s  = b_valid & b_ready;
  assign mux_in_a  = hold_a_r;
  assign mux_in_b  = hold_b_r;
  assign mux_sel_a = grant_a_s;

  // Holding registers and full flags; a capture wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_a_r <= 1'b0;
      full_b_r <= 1'b0;
      hold_a_r <= '0;
      hold_b_r <= '0;
    end else begin
      if (a_fire_s) begin
        full_a_r <= 1'b1;
        hold_a_r <= a_data;
      end else if (fire_s && grant_a_s) begin
        full_a_r <= 1'b0;
      end
      if (b_fire_s) begin
        full_b_r <= 1'b1;
        hold_b_r <= b_data;
      end else if (fire_s && !grant_a_s) begin
        full_b_r <= 1'b0;
      end
    end
  end

  // Stall FSM: latch the grant when the consumer back-pressures.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      grant_q_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (out_valid && !out_ready) begin
            state_r   <= OFFER;
            grant_q_r <= grant_a_s;
          end
        end
        OFFER: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Round-robin bookkeeping on every output fire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pref_r     <= 1'b1;
      run_cnt_r  <= '0;
      last_sel_r <= 1'b1;
    end else if (fire_s) begin
      last_sel_r <= grant_a_s;
      if (grant_a_s != pref_r) begin
        pref_r    <= grant_a_s;
        run_cnt_r <= ONE_C;
      end else if (run_cnt_r >= BURST_C) begin
        run_cnt_r <= BURST_C;
      end else begin
        run_cnt_r <= run_cnt_r + ONE_C;
      end
    end
  end

`ifdef SCALE_MUX_ARB_STATS_EN
  logic [15:0] grant_cnt_a_r;
  logic [15:0] grant_cnt_b_r;

  // Saturating per-channel fire counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt_a_r <= 16'h0000;
      grant_cnt_b_r <= 16'h0000;
    end else if (fire_s) begin
      if (grant_a_s && grant_cnt_a_r != 16'hFFFF) begin
        grant_cnt_a_r <= grant_cnt_a_r + 16'h0001;
      end
      if (!grant_a_s && grant_cnt_b_r != 16'hFFFF) begin
        grant_cnt_b_r <= grant_cnt_b_r + 16'h0001;
      end
    end
  end

  assign grant_cnt_a = grant_cnt_a_r;
  assign grant_cnt_b = grant_cnt_b_r;
`endif

endmodule

// File: tb/tb_scale_mux_arb.sv
// Directed self-checking bench for scale_mux_arb; u0 runs BURST=1, u1 runs BURST=3.
// Grant counters are checked when SCALE_MUX_ARB_STATS_EN is defined.
module tb_scale_mux_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, out_ready;
  logic       a_ready [2];
  logic       b_ready [2];
  logic [7:0] mux_in_a [2];
  logic [7:0] mux_in_b [2];
  logic       mux_sel_a [2];
  logic       out_valid [2];
`ifdef SCALE_MUX_ARB_STATS_EN
  logic [15:0] grant_cnt_a [2];
  logic [15:0] grant_cnt_b [2];
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scale_mux_arb #(.WIDTH(8), .BURST(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready[0]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready[0]),
    .mux_in_a(mux_in_a[0]), .mux_in_b(mux_in_b[0]), .mux_sel_a(mux_sel_a[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready)
`ifdef SCALE_MUX_ARB_STATS_EN
    , .grant_cnt_a(grant_cnt_a[0]), .grant_cnt_b(grant_cnt_b[0])
`endif
  );

  scale_mux_arb #(.WIDTH(8), .BURST(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready[1]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready[1]),
    .mux_in_a(mux_in_a[1]), .mux_in_b(mux_in_b[1]), .mux_sel_a(mux_sel_a[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready)
`ifdef SCALE_MUX_ARB_STATS_EN
    , .grant_cnt_a(grant_cnt_a[1]), .grant_cnt_b(grant_cnt_b[1])
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = 8'hAA; b_data = 8'hBB;
    repeat (3) cyc();
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++; if (a_ready[d] !== 1'b0) begin fails++; $display("FAIL reset_a_ready[%0d] got %b exp 0", d, a_ready[d]); end
      tests++; if (b_ready[d] !== 1'b0) begin fails++; $display("FAIL reset_b_ready[%0d] got %b exp 0", d, b_ready[d]); end
      tests++; if (out_valid[d] !== 1'b0) begin fails++; $display("FAIL reset_out_valid[%0d] got %b exp 0", d, out_valid[d]); end
      tests++; if (mux_sel_a[d] !== 1'b1) begin fails++; $display("FAIL reset_sel[%0d] got %b exp 1", d, mux_sel_a[d]); end
      tests++; if (mux_in_a[d] !== 8'h00) begin fails++; $display("FAIL reset_in_a[%0d] got %h exp 00", d, mux_in_a[d]); end
      tests++; if (mux_in_b[d] !== 8'h00) begin fails++; $display("FAIL reset_in_b[%0d] got %h exp 00", d, mux_in_b[d]); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1'b1; a_data = 8'h5A; out_ready = 1'b1;
    #1;
    tests++; if (a_ready[0] !== 1'b1) begin fails++; $display("FAIL single_a_ready got %b exp 1", a_ready[0]); end
    cyc();
    a_valid = 1'b0;
    #1;
    tests++; if (out_valid[0] !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", out_valid[0]); end
    tests++; if (mux_sel_a[0] !== 1'b1) begin fails++; $display("FAIL single_sel got %b exp 1", mux_sel_a[0]); end
    tests++; if (mux_in_a[0] !== 8'h5A) begin fails++; $display("FAIL single_data got %h exp 5a", mux_in_a[0]); end
    cyc();
    tests++; if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", out_valid[0]); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_rr [8] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    logic [7:0] got;
    int ia = 0, ib = 0, n = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n < 8; c++) begin
      a_valid = (ia < 4); a_data = 8'h10 + 8'(ia);
      b_valid = (ib < 4); b_data = 8'h20 + 8'(ib);
      #1;
      if (out_valid[0]) begin
        got = mux_sel_a[0] ? mux_in_a[0] : mux_in_b[0];
        tests++;
        if (got !== exp_rr[n]) begin fails++; $display("FAIL rr_out[%0d] got %h exp %h", n, got, exp_rr[n]); end
        n++;
      end
      if (a_valid && a_ready[0]) ia++;
      if (b_valid && b_ready[0]) ib++;
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tests++; if (n != 8) begin fails++; $display("FAIL rr_count got %0d exp 8", n); end
    repeat (3) cyc();
  endtask

  task automatic test_burst();
    logic exp_sel [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] got, want;
    int ia = 0, ib = 0, ka = 0, kb = 0, n = 0, max_run = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n < 9; c++) begin
      a_valid = 1'b1; a_data = 8'h30 + 8'(ia);
      b_valid = 1'b1; b_data = 8'h40 + 8'(ib);
      #1;
      if (int'(u1.run_cnt_r) > max_run) max_run = int'(u1.run_cnt_r);
      if (out_valid[1]) begin
        tests++;
        if (mux_sel_a[1] !== exp_sel[n]) begin fails++; $display("FAIL burst_sel[%0d] got %b exp %b", n, mux_sel_a[1], exp_sel[n]); end
        got  = mux_sel_a[1] ? mux_in_a[1] : mux_in_b[1];
        want = exp_sel[n] ? (8'h30 + 8'(ka)) : (8'h40 + 8'(kb));
        tests++;
        if (got !== want) begin fails++; $display("FAIL burst_data[%0d] got %h exp %h", n, got, want); end
        if (exp_sel[n]) ka++; else kb++;
        n++;
      end
      if (a_ready[1]) ia++;
      if (b_ready[1]) ib++;
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tests++; if (n != 9) begin fails++; $display("FAIL burst_count got %0d exp 9", n); end
    tests++; if (max_run != 3) begin fails++; $display("FAIL burst_run_max got %0d exp 3", max_run); end
    repeat (4) cyc();
  endtask

  task automatic test_stall_lock();
    do_reset();
    out_ready = 1'b0; b_valid = 1'b1; b_data = 8'h77;
    cyc();
    b_valid = 1'b0;
    #1;
    tests++; if (mux_sel_a[0] !== 1'b0) begin fails++; $display("FAIL stall1_sel got %b exp 0", mux_sel_a[0]); end
    cyc();
    a_valid = 1'b1; a_data = 8'h88;
    #1;
    tests++; if (a_ready[0] !== 1'b1) begin fails++; $display("FAIL stall2_a_ready got %b exp 1", a_ready[0]); end
    cyc();
    a_valid = 1'b0;
    for (int s = 3; s <= 4; s++) begin
      #1;
      tests++; if (mux_sel_a[0] !== 1'b0) begin fails++; $display("FAIL stall%0d_sel got %b exp 0", s, mux_sel_a[0]); end
      tests++; if (mux_in_b[0] !== 8'h77) begin fails++; $display("FAIL stall%0d_in_b got %h exp 77", s, mux_in_b[0]); end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (mux_sel_a[0] !== 1'b0) begin fails++; $display("FAIL stall_fire_b_sel got %b exp 0", mux_sel_a[0]); end
    tests++; if (a_ready[0] !== 1'b0) begin fails++; $display("FAIL stall_fire_b_a_ready got %b exp 0", a_ready[0]); end
    cyc();
    tests++; if (mux_sel_a[0] !== 1'b1) begin fails++; $display("FAIL stall_fire_a_sel got %b exp 1", mux_sel_a[0]); end
    tests++; if (mux_in_a[0] !== 8'h88) begin fails++; $display("FAIL stall_fire_a_data got %h exp 88", mux_in_a[0]); end
    tests++; if (out_valid[0] !== 1'b1) begin fails++; $display("FAIL stall_fire_a_valid got %b exp 1", out_valid[0]); end
    cyc();
    tests++; if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL stall_drain got %b exp 0", out_valid[0]); end
  endtask

  task automatic test_stats_reset();
    int na = 0, nb = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && na < 5; c++) begin
      a_valid = 1'b1; a_data = 8'h50 + 8'(na);
      #1;
      if (a_ready[0]) na++;
      cyc();
    end
    a_valid = 1'b0;
    repeat (2) cyc();
    for (int c = 0; c < 20 && nb < 3; c++) begin
      b_valid = 1'b1; b_data = 8'h60 + 8'(nb);
      #1;
      if (b_ready[0]) nb++;
      cyc();
    end
    b_valid = 1'b0;
    repeat (2) cyc();
`ifdef SCALE_MUX_ARB_STATS_EN
    tests++; if (grant_cnt_a[0] !== 16'd5) begin fails++; $display("FAIL stats_a got %0d exp 5", grant_cnt_a[0]); end
    tests++; if (grant_cnt_b[0] !== 16'd3) begin fails++; $display("FAIL stats_b got %0d exp 3", grant_cnt_b[0]); end
`endif
    out_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    repeat (2) cyc();
    tests++; if (out_valid[0] !== 1'b1) begin fails++; $display("FAIL midrst_pre got %b exp 1", out_valid[0]); end
    rst_n = 1'b0;
    cyc();
    tests++; if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b exp 0", out_valid[0]); end
`ifdef SCALE_MUX_ARB_STATS_EN
    tests++; if (grant_cnt_a[0] !== 16'd0) begin fails++; $display("FAIL midrst_cnt_a got %0d exp 0", grant_cnt_a[0]); end
    tests++; if (grant_cnt_b[0] !== 16'd0) begin fails++; $display("FAIL midrst_cnt_b got %0d exp 0", grant_cnt_b[0]); end
`endif
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    cyc();
    tests++; if (out_valid[0] !== 1'b0) begin fails++; $display("FAIL midrst_after got %b exp 0", out_valid[0]); end
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_stall_lock();
    test_stats_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
